// File: rtl/dm_bus_arbiter.sv
// Two-master round-robin arbiter for the shared data-memory/bridge bus.
// One transaction at a time; slave handshake with timeout; CPU flush neutralises master-0 stores.
module dm_bus_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic [3:0]  m0_byteen,
   input  logic [31:0] m0_wdata,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic [3:0]  m1_byteen,
   input  logic [31:0] m1_wdata,
   output logic        m0_gnt,
   output logic        m1_gnt,
   output logic        m0_done,
   output logic        m1_done,
   output logic [31:0] m0_rdata,
   output logic [31:0] m1_rdata,
   output logic        m0_err,
   output logic        m1_err,
   input  logic        cpu_kill,
   output logic        s_valid,
   output logic [31:0] s_addr,
   output logic [3:0]  s_byteen,
   output logic [31:0] s_wdata,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic        owner
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_next;
   logic        last;
   logic [7:0]  cnt;
   logic [31:0] addr_q;
   logic [3:0]  byteen_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        req0_eff;
   logic        sel;
   logic        sel_valid;
   logic        timed_out;
   logic        kill_m0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         last     <= 1'b1;
         owner    <= 1'b0;
         cnt      <= '0;
         addr_q   <= '0;
         byteen_q <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (sel_valid) begin
                  owner    <= sel;
                  addr_q   <= sel ? m1_addr   : m0_addr;
                  byteen_q <= sel ? m1_byteen : m0_byteen;
                  wdata_q  <= sel ? m1_wdata  : m0_wdata;
                  cnt      <= '0;
               end
            end
            ACCESS: begin
               // A flushed store degrades to a read for the rest of the access.
               if (kill_m0)
                  byteen_q <= '0;
               if (s_ready) begin
                  rdata_q <= s_rdata;
                  err_q   <= 1'b0;
               end else if (timed_out) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RESP: last <= owner;
            default: ;
         endcase
      end
   end

   always_comb begin
      req0_eff  = m0_req & ~cpu_kill;
      sel_valid = req0_eff | m1_req;
      sel       = 1'b0;
      if (req0_eff && m1_req)
         sel = ~last;
      else if (m1_req)
         sel = 1'b1;
      timed_out = (cnt == CNT_LAST);
      kill_m0   = (state == ACCESS) && !owner && cpu_kill;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (sel_valid) state_next = ACCESS;
         ACCESS:  if (s_ready || timed_out) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      m0_gnt   = 1'b0;
      m1_gnt   = 1'b0;
      m0_done  = 1'b0;
      m1_done  = 1'b0;
      m0_rdata = '0;
      m1_rdata = '0;
      m0_err   = 1'b0;
      m1_err   = 1'b0;
      s_valid  = 1'b0;
      s_addr   = '0;
      s_byteen = '0;
      s_wdata  = '0;
      if (state == ACCESS) begin
         s_valid  = 1'b1;
         s_addr   = addr_q;
         s_wdata  = wdata_q;
         s_byteen = kill_m0 ? 4'b0000 : byteen_q;
         // cnt only stays at zero during the first ACCESS cycle.
         if (cnt == 8'd0) begin
            m0_gnt = ~owner;
            m1_gnt = owner;
         end
      end
      if (state == RESP) begin
         if (owner) begin
            m1_done  = 1'b1;
            m1_rdata = rdata_q;
            m1_err   = err_q;
         end else begin
            m0_done  = 1'b1;
            m0_rdata = rdata_q;
            m0_err   = err_q;
         end
      end
   end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed testbench for dm_bus_arbiter (TIMEOUT=4), cycle-exact expected values.
module tb_dm_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m1_req;
   logic [31:0] m0_addr, m1_addr;
   logic [3:0]  m0_byteen, m1_byteen;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_done, m1_done;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_err, m1_err;
   logic        cpu_kill;
   logic        s_valid;
   logic [31:0] s_addr;
   logic [3:0]  s_byteen;
   logic [31:0] s_wdata;
   logic        s_ready;
   logic [31:0] s_rdata;
   logic        owner;

   int vectors = 0;
   int miscompares = 0;

   dm_bus_arbiter #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_byteen(m0_byteen), .m0_wdata(m0_wdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_byteen(m1_byteen), .m1_wdata(m1_wdata),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
      .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_err(m0_err), .m1_err(m1_err),
      .cpu_kill(cpu_kill), .s_valid(s_valid), .s_addr(s_addr), .s_byteen(s_byteen),
      .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata), .owner(owner)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [199:0] all_outs();
      return {m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata, m0_err, m1_err,
              s_valid, s_addr, s_byteen, s_wdata, owner};
   endfunction

   task automatic clear_inputs;
      m0_req = 0; m1_req = 0; cpu_kill = 0; s_ready = 0; s_rdata = '0;
      m0_addr = '0; m0_byteen = '0; m0_wdata = '0;
      m1_addr = '0; m1_byteen = '0; m1_wdata = '0;
   endtask

   task automatic test_reset;
      reset = 0;
      clear_inputs();
      tick();
      tick();
      #1;
      vectors++; if (all_outs() !== '0) begin miscompares++; $display("FAIL reset_outputs: got %h expected 0", all_outs()); end
      reset = 1;
      tick();
   endtask

   task automatic test_single_read;
      m0_req = 1; m0_addr = 32'h0000_1000; m0_byteen = 4'b0000;
      tick();
      s_ready = 1; s_rdata = 32'hDEAD_BEEF; m0_req = 0;
      #1;
      vectors++; if (m0_gnt !== 1'b1) begin miscompares++; $display("FAIL read_gnt: got %b expected 1", m0_gnt); end
      vectors++; if (s_addr !== 32'h1000) begin miscompares++; $display("FAIL read_saddr: got %h expected 00001000", s_addr); end
      vectors++; if ({s_valid, s_byteen} !== 5'b1_0000) begin miscompares++; $display("FAIL read_svalid_byteen: got %b expected 10000", {s_valid, s_byteen}); end
      tick();
      s_ready = 0;
      #1;
      vectors++; if ({m0_done, m0_err, m1_done} !== 3'b100) begin miscompares++; $display("FAIL read_done: got %b expected 100", {m0_done, m0_err, m1_done}); end
      vectors++; if (m0_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL read_rdata: got %h expected deadbeef", m0_rdata); end
      vectors++; if ({s_valid, s_byteen} !== 5'b0) begin miscompares++; $display("FAIL read_resp_bus: got %b expected 00000", {s_valid, s_byteen}); end
      tick();
      #1;
      vectors++; if ({m0_done, m0_rdata} !== 33'b0) begin miscompares++; $display("FAIL read_after_done: got %h expected 0", {m0_done, m0_rdata}); end
      clear_inputs();
      tick();
   endtask

   task automatic test_contention;
      logic exp;
      reset = 0;
      tick();
      reset = 1;
      m0_addr = 32'h1000; m0_byteen = 4'b0000; m0_wdata = '0;
      m1_addr = 32'h2004; m1_byteen = 4'b1100; m1_wdata = 32'h1234_0000;
      m0_req = 1; m1_req = 1; s_ready = 1; s_rdata = 32'h0A0B_0C0D;
      for (int i = 0; i < 4; i++) begin
         exp = i[0];
         tick();
         #1;
         vectors++; if ({m0_gnt, m1_gnt} !== (exp ? 2'b01 : 2'b10)) begin miscompares++; $display("FAIL contention_gnt%0d: got %b expected %b", i, {m0_gnt, m1_gnt}, exp ? 2'b01 : 2'b10); end
         if (exp) begin
            vectors++; if ({s_addr, s_byteen, s_wdata} !== {32'h2004, 4'b1100, 32'h1234_0000}) begin miscompares++; $display("FAIL contention_m1_bus: got %h %b %h expected 00002004 1100 12340000", s_addr, s_byteen, s_wdata); end
         end
         tick();
         if (exp) m1_req = 0; else m0_req = 0;
         #1;
         vectors++; if ({m0_done, m1_done} !== (exp ? 2'b01 : 2'b10)) begin miscompares++; $display("FAIL contention_done%0d: got %b expected %b", i, {m0_done, m1_done}, exp ? 2'b01 : 2'b10); end
         tick();
         if (exp) m1_req = 1; else m0_req = 1;
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_kill_idle;
      m0_req = 1; m0_addr = 32'h5000; cpu_kill = 1; s_ready = 1; s_rdata = 32'h1111_2222;
      tick();
      cpu_kill = 0;
      #1;
      vectors++; if ({m0_gnt, s_valid} !== 2'b00) begin miscompares++; $display("FAIL kill_idle_nogrant: got %b expected 00", {m0_gnt, s_valid}); end
      tick();
      m0_req = 0;
      #1;
      vectors++; if (m0_gnt !== 1'b1) begin miscompares++; $display("FAIL kill_idle_late_gnt: got %b expected 1", m0_gnt); end
      tick();
      #1;
      vectors++; if ({m0_done, m0_rdata} !== {1'b1, 32'h1111_2222}) begin miscompares++; $display("FAIL kill_idle_done: got %h expected 111112222", {m0_done, m0_rdata}); end
      clear_inputs();
      tick();
   endtask

   task automatic test_kill_access;
      m0_req = 1; m0_addr = 32'h7f20; m0_byteen = 4'b1111; m0_wdata = 32'hA5A5_A5A5;
      tick();
      m0_req = 0;
      #1;
      vectors++; if ({m0_gnt, s_byteen} !== 5'b1_1111) begin miscompares++; $display("FAIL kill_acc_first: got %b expected 11111", {m0_gnt, s_byteen}); end
      tick();
      cpu_kill = 1;
      #1;
      vectors++; if (s_byteen !== 4'b0000) begin miscompares++; $display("FAIL kill_acc_comb: got %b expected 0000", s_byteen); end
      tick();
      cpu_kill = 0;
      #1;
      vectors++; if ({s_valid, s_byteen, s_addr} !== {1'b1, 4'b0000, 32'h7f20}) begin miscompares++; $display("FAIL kill_acc_latched: got %h expected 00007f20 valid", {s_valid, s_byteen, s_addr}); end
      s_ready = 1; s_rdata = 32'h3333_4444;
      tick();
      s_ready = 0;
      #1;
      vectors++; if ({m0_done, m0_err} !== 2'b10) begin miscompares++; $display("FAIL kill_acc_done: got %b expected 10", {m0_done, m0_err}); end
      clear_inputs();
      tick();
   endtask

   task automatic test_timeout;
      m1_req = 1; m1_addr = 32'h3000; s_rdata = 32'h5555_5555;
      for (int i = 0; i < 4; i++) begin
         tick();
         m1_req = 0;
         #1;
         vectors++; if ({s_valid, m1_done} !== 2'b10) begin miscompares++; $display("FAIL timeout_access%0d: got %b expected 10", i, {s_valid, m1_done}); end
      end
      tick();
      #1;
      vectors++; if ({s_valid, m1_done, m1_err} !== 3'b011) begin miscompares++; $display("FAIL timeout_done: got %b expected 011", {s_valid, m1_done, m1_err}); end
      vectors++; if (m1_rdata !== 32'h0) begin miscompares++; $display("FAIL timeout_rdata: got %h expected 0", m1_rdata); end
      tick();
      m1_req = 1; s_ready = 1; s_rdata = 32'h1357_9BDF;
      tick();
      m1_req = 0;
      tick();
      #1;
      vectors++; if ({m1_done, m1_err, m1_rdata} !== {2'b10, 32'h1357_9BDF}) begin miscompares++; $display("FAIL timeout_next_ok: got %h expected 213579bdf", {m1_done, m1_err, m1_rdata}); end
      clear_inputs();
      tick();
   endtask

   task automatic test_ready_at_timeout;
      m0_req = 1; m0_addr = 32'h4000; s_rdata = 32'h0BAD_F00D;
      tick();
      m0_req = 0;
      tick();
      tick();
      tick();
      s_ready = 1;
      #1;
      vectors++; if (s_valid !== 1'b1) begin miscompares++; $display("FAIL edge_still_access: got %b expected 1", s_valid); end
      tick();
      s_ready = 0;
      #1;
      vectors++; if ({m0_done, m0_err, m0_rdata} !== {2'b10, 32'h0BAD_F00D}) begin miscompares++; $display("FAIL edge_ready_wins: got %h expected 20badf00d", {m0_done, m0_err, m0_rdata}); end
      clear_inputs();
      tick();
   endtask

   task automatic test_reset_mid;
      int dones;
      dones = 0;
      m0_req = 1; m0_addr = 32'h6000; m0_byteen = 4'b0011; m0_wdata = 32'hFFFF_0001;
      tick();
      m0_req = 0;
      tick();
      reset = 0;
      m0_req = 1; m1_req = 1;
      tick();
      #1;
      vectors++; if (all_outs() !== '0) begin miscompares++; $display("FAIL reset_mid_outputs: got %h expected 0", all_outs()); end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (m0_done || m1_done) dones++;
      end
      vectors++; if (dones !== 0) begin miscompares++; $display("FAIL reset_mid_no_done: got %0d expected 0", dones); end
      reset = 1;
      tick();
      #1;
      vectors++; if ({m0_gnt, m1_gnt} !== 2'b10) begin miscompares++; $display("FAIL reset_mid_first_gnt: got %b expected 10", {m0_gnt, m1_gnt}); end
      clear_inputs();
      s_ready = 1;
      tick();
      tick();
      s_ready = 0;
      tick();
   endtask

   initial begin
      reset = 0;
      clear_inputs();
      test_reset();
      test_single_read();
      test_contention();
      test_kill_idle();
      test_kill_access();
      test_timeout();
      test_ready_at_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dm_bus_arbiter.md
# dm_bus_arbiter

Two-master arbiter sharing the single data-memory/bridge bus between the CPU memory stage (master 0) and an auxiliary master (master 1, e.g. a DMA/debug engine). It grants one transaction at a time with round-robin fairness and drives the slave-side address, byte enables and write data. It waits on a slave ready handshake with a timeout, and returns read data and completion. A CPU exception/interrupt flush can cancel or neutralise master-0 stores, so the arbiter sits between the M-stage byte-enable logic and the bridge.

## Interface
- TIMEOUT, 15, ACCESS cycles without s_ready before the transaction is forced to complete with error; legal range 1..255
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low (0 = reset, sampled on rising clk)
- m0_req / m1_req  input  1  level request; held with fields stable until mX_gnt
- m0_addr / m1_addr  input  32  byte address
- m0_byteen / m1_byteen  input  4  byte enables; 4'b0000 = read, nonzero = write
- m0_wdata / m1_wdata  input  32  write data, already lane-aligned
- m0_gnt / m1_gnt  output  1  one-cycle pulse: fields latched, transaction started
- m0_done / m1_done  output  1  one-cycle pulse: transaction complete
- m0_rdata / m1_rdata  output  32  read data, valid only while mX_done=1, else 0
- m0_err / m1_err  output  1  timeout flag, valid only while mX_done=1
- cpu_kill  input  1  exception/interrupt flush from CPU
- s_valid  output  1  slave access active
- s_addr  output  32  latched address
- s_byteen  output  4  latched byte enables (after kill masking)
- s_wdata  output  32  latched write data
- s_ready  input  1  slave accepts/completes access this cycle
- s_rdata  input  32  slave read data, sampled when s_ready=1
- owner  output  1  master of current/last transaction

## Operation
- States: IDLE, ACCESS, RESP. Requests are sampled only in IDLE.
- IDLE:
  - Effective m0 request is m0_req & ~cpu_kill.
  - If only one master is requesting, select it. If both are requesting, select the master != last.
  - Register `last` resets to 1, so master 0 wins the first contention.
  - On selection, latch addr/byteen/wdata, set owner, clear cnt, go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - mX_gnt=1 for the owner in the first ACCESS cycle only.
  - s_valid=1; s_addr/s_byteen/s_wdata come from the latches.
  - If s_ready=1: capture s_rdata, err=0, go to RESP.
  - Else if cnt==TIMEOUT-1: captured rdata=0, err=1, go to RESP.
  - Else cnt+1 (8-bit counter).
- Kill during ACCESS: if owner=0 and cpu_kill=1 in ACCESS, the latched byteen clears to 4'b0000 at that edge.
  - s_byteen is also forced to 0 combinationally in the same cycle, so a flushed store never writes.
  - The access continues as a read and still completes with done.
  - cpu_kill has no effect on master-1 transactions.
- RESP: owner's done=1, rdata/err presented; last<=owner; go to IDLE.
- Requesters must drop req by the done cycle to avoid re-issue.
- Outside their valid windows, rdata/err are 0. s_addr/s_wdata are 0 when s_valid=0.

## Timing
- Reset (reset=0 at an edge): state IDLE, last=1, cnt=0, latches 0.
  - All outputs 0: gnt, done, rdata, err, s_valid, s_addr, s_byteen, s_wdata, owner.
  - Reset mid-ACCESS or mid-RESP aborts with no done pulse; s_valid is low from the next cycle.
- Request seen in IDLE at edge k: gnt and s_valid high in cycle k+1.
- If s_ready=1 in cycle k+1: done in cycle k+2, IDLE in cycle k+3.
  - Minimum request-to-done is 2 cycles; back-to-back throughput is one transaction per 3 cycles.
- Each s_ready-low cycle adds one cycle. Timeout done arrives in cycle k+1+TIMEOUT.
- cpu_kill and m0_req high in the same IDLE cycle: m0 is not granted. m1 may be granted that cycle.
- s_ready while not in ACCESS is ignored. s_ready and timeout in the same cycle: ready wins, err=0.

## Test plan
- Single m0 read: m0_req=1, addr=0x1000, byteen=0.
  - Required: gnt in cycle 1; s_ready=1 with s_rdata=0xDEADBEEF in cycle 1.
  - Required: m0_done=1 with rdata=0xDEADBEEF in cycle 2; s_byteen=0 throughout.
- Contention: both masters request continuously after reset, dropping req at done and re-raising next cycle, s_ready always 1.
  - Required: grants alternate m0, m1, m0, m1.
  - Required: m1 store addr=0x2004, byteen=4'b1100, wdata=0x12340000 appears unchanged on s_* during its ACCESS.
- Kill in IDLE: m0_req=1 with cpu_kill=1 for one cycle, then cpu_kill=0.
  - Required: no m0_gnt in cycle 1; gnt one cycle later.
- Kill in ACCESS: m0 store byteen=4'b1111 to 0x7f20, s_ready held low, cpu_kill=1 in the second ACCESS cycle.
  - Required: s_byteen=4'b1111 in the first ACCESS cycle and 4'b0000 from the kill cycle on.
  - Required: done still pulses after s_ready rises.
- Timeout, TIMEOUT=4: m1 request, s_ready never asserted.
  - Required: s_valid for exactly 4 cycles, then m1_done=1, m1_err=1, m1_rdata=0.
  - Required: next transaction has err=0.
- Reset mid-transaction: reset=0 during ACCESS.
  - Required: next cycle all outputs 0, no done pulse.
  - Required: after reset release with both masters requesting, m0 is granted first.
